// File: rtl/duty_ramp.sv
// Duty-word conditioner for the 11-bit PWM stage: period-aligned slew limiting,
// soft start/stop on en, and a latched over-current shutdown.
module duty_ramp #(
    parameter int unsigned STEP      = 16,
    parameter int unsigned DUTY_MAX  = 2000,
    parameter int unsigned FAULT_LIM = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [10:0] duty_tgt,
    input  logic        PWM_synch,
    input  logic        OVR_I_blank_n,
    input  logic        OVR_I,
    output logic [10:0] duty,
    output logic        ramping,
    output logic        shutdown
);

    localparam logic [11:0] STEP_W = 12'(STEP);
    localparam logic [10:0] DMAX   = 11'(DUTY_MAX);
    localparam logic [3:0]  LIM    = 4'(FAULT_LIM);

    typedef enum logic [1:0] {IDLE, RUN, DOWN, FAULT} state_t;

    state_t      state_q;
    logic [10:0] duty_q;
    logic        ramping_q;
    logic        shutdown_q;
    logic        flag_q;
    logic [3:0]  cnt_q;

    logic [10:0] tgt_eff_d;
    logic [10:0] up_duty_d;
    logic [10:0] dn_duty_d;
    logic        flag_d;
    logic [3:0]  cnt_inc_d;
    logic        trip_d;

    // Both operands are widened to 12 bits so the +/-STEP move can never wrap.
    function automatic logic [10:0] step_toward(input logic [10:0] cur, input logic [10:0] tgt);
        logic [11:0] c;
        logic [11:0] t;
        logic [11:0] r;
        c = {1'b0, cur};
        t = {1'b0, tgt};
        if (t >= c) begin
            r = (t - c <= STEP_W) ? t : c + STEP_W;
        end else begin
            r = (c - t <= STEP_W) ? t : c - STEP_W;
        end
        return r[10:0];
    endfunction

    always_comb begin
        tgt_eff_d = (duty_tgt > DMAX) ? DMAX : duty_tgt;
        up_duty_d = step_toward(duty_q, tgt_eff_d);
        dn_duty_d = step_toward(duty_q, 11'd0);
        // The sample on the synch cycle itself belongs to the period now ending.
        flag_d    = flag_q | (OVR_I & OVR_I_blank_n);
        cnt_inc_d = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
        trip_d    = PWM_synch && flag_d && (state_q != FAULT) && (cnt_inc_d >= LIM);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            duty_q     <= 11'd0;
            ramping_q  <= 1'b0;
            shutdown_q <= 1'b0;
            flag_q     <= 1'b0;
            cnt_q      <= 4'd0;
        end else begin
            if (PWM_synch) begin
                flag_q <= 1'b0;
                cnt_q  <= flag_d ? cnt_inc_d : 4'd0;
            end else begin
                flag_q <= flag_d;
            end

            if (trip_d) begin
                state_q    <= FAULT;
                duty_q     <= 11'd0;
                ramping_q  <= 1'b0;
                shutdown_q <= 1'b1;
            end else if (PWM_synch) begin
                case (state_q)
                    IDLE: begin
                        if (en) begin
                            state_q   <= RUN;
                            duty_q    <= up_duty_d;
                            ramping_q <= (up_duty_d != tgt_eff_d);
                        end else begin
                            duty_q    <= 11'd0;
                            ramping_q <= 1'b0;
                        end
                    end
                    RUN, DOWN: begin
                        if (en) begin
                            state_q   <= RUN;
                            duty_q    <= up_duty_d;
                            ramping_q <= (up_duty_d != tgt_eff_d);
                        end else if (dn_duty_d == 11'd0) begin
                            state_q   <= IDLE;
                            duty_q    <= 11'd0;
                            ramping_q <= 1'b0;
                        end else begin
                            state_q   <= DOWN;
                            duty_q    <= dn_duty_d;
                            ramping_q <= 1'b1;
                        end
                    end
                    FAULT: begin
                        duty_q    <= 11'd0;
                        ramping_q <= 1'b0;
                        if (!en) begin
                            state_q    <= IDLE;
                            shutdown_q <= 1'b0;
                            cnt_q      <= 4'd0;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        duty_q  <= 11'd0;
                    end
                endcase
            end
        end
    end

    assign duty     = duty_q;
    assign ramping  = ramping_q;
    assign shutdown = shutdown_q;

endmodule

// File: tb/tb_duty_ramp.sv
// Directed bench for duty_ramp: one PWM period = 3 idle clocks + 1 synch clock.
module tb_duty_ramp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [10:0] duty_tgt;
    logic        PWM_synch;
    logic        OVR_I_blank_n;
    logic        OVR_I;
    logic [10:0] duty;
    logic        ramping;
    logic        shutdown;

    int checks = 0;
    int errors = 0;

    duty_ramp #(.STEP(16), .DUTY_MAX(2000), .FAULT_LIM(4)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .duty_tgt(duty_tgt),
        .PWM_synch(PWM_synch), .OVR_I_blank_n(OVR_I_blank_n), .OVR_I(OVR_I),
        .duty(duty), .ramping(ramping), .shutdown(shutdown)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [10:0] tgt;
        logic [10:0] duty;
        logic        ramp;
        logic        sd;
    } vec_t;

    vec_t vecs[21];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_out(input string name, input int d, input int r, input int s);
        chk({name, ".duty"}, int'(duty), d);
        chk({name, ".ramping"}, int'(ramping), r);
        chk({name, ".shutdown"}, int'(shutdown), s);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ov: assert OVR_I; synch_only: only on the synch clock. Returns after the synch edge.
    task automatic period(input logic e, input logic [10:0] t, input logic ov,
                          input logic bl, input logic synch_only);
        en = e;
        duty_tgt = t;
        OVR_I_blank_n = bl;
        for (int i = 0; i < 3; i++) begin
            OVR_I = ov & ~synch_only;
            PWM_synch = 1'b0;
            @(negedge clk);
        end
        OVR_I = ov;
        PWM_synch = 1'b1;
        @(negedge clk);
        PWM_synch = 1'b0;
        OVR_I = 1'b0;
    endtask

    initial begin
        int exp_d;
        int n;
        rst_n = 1'b0; en = 1'b0; duty_tgt = '0; PWM_synch = 1'b0;
        OVR_I_blank_n = 1'b1; OVR_I = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk_out("reset", 0, 0, 0);

        // Ramp up, soft stop, restart, soft stop to IDLE.
        for (int i = 0; i < 6; i++) vecs[i] = '{1'b1, 11'd100, 11'(16 * (i + 1)), 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 11'd100, 11'd100, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 11'd100, 11'd84,  1'b1, 1'b0};
        vecs[8]  = '{1'b0, 11'd100, 11'd68,  1'b1, 1'b0};
        vecs[9]  = '{1'b0, 11'd100, 11'd52,  1'b1, 1'b0};
        vecs[10] = '{1'b1, 11'd100, 11'd68,  1'b1, 1'b0};
        vecs[11] = '{1'b1, 11'd100, 11'd84,  1'b1, 1'b0};
        vecs[12] = '{1'b1, 11'd100, 11'd100, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 11'd100, 11'd84,  1'b1, 1'b0};
        vecs[14] = '{1'b0, 11'd100, 11'd68,  1'b1, 1'b0};
        vecs[15] = '{1'b0, 11'd100, 11'd52,  1'b1, 1'b0};
        vecs[16] = '{1'b0, 11'd100, 11'd36,  1'b1, 1'b0};
        vecs[17] = '{1'b0, 11'd100, 11'd20,  1'b1, 1'b0};
        vecs[18] = '{1'b0, 11'd100, 11'd4,   1'b1, 1'b0};
        vecs[19] = '{1'b0, 11'd100, 11'd0,   1'b0, 1'b0};
        vecs[20] = '{1'b0, 11'd100, 11'd0,   1'b0, 1'b0};
        for (int i = 0; i < 21; i++) begin
            period(vecs[i].en, vecs[i].tgt, 1'b0, 1'b1, 1'b0);
            chk_out($sformatf("vec%0d", i), int'(vecs[i].duty), int'(vecs[i].ramp), int'(vecs[i].sd));
            $display("vec %0d en=%0d tgt=%0d duty=%0d ramping=%0d shutdown=%0d",
                     i, vecs[i].en, vecs[i].tgt, duty, ramping, shutdown);
        end
        // No change while idle between synchs: duty_tgt wiggle off-synch.
        en = 1'b1; duty_tgt = 11'd500;
        repeat (3) @(negedge clk);
        chk_out("no_synch_hold", 0, 0, 0);

        // Clamp at DUTY_MAX, then a small step down lands exactly.
        do_reset();
        for (int i = 0; i < 7; i++) period(1'b1, 11'd100, 1'b0, 1'b1, 1'b0);
        chk_out("settle100", 100, 0, 0);
        exp_d = 100;
        n = 0;
        while (exp_d != 2000 && n < 200) begin
            exp_d = (exp_d + 16 > 2000) ? 2000 : exp_d + 16;
            period(1'b1, 11'd2047, 1'b0, 1'b1, 1'b0);
            chk("clamp.duty", int'(duty), exp_d);
            chk("clamp.ramping", int'(ramping), (exp_d != 2000) ? 1 : 0);
            n++;
        end
        $display("clamp reached duty=%0d after %0d periods", duty, n);
        period(1'b1, 11'd2047, 1'b0, 1'b1, 1'b0);
        chk_out("clamp_hold", 2000, 0, 0);
        period(1'b1, 11'd1990, 1'b0, 1'b1, 1'b0);
        chk_out("step_down_1990", 1990, 0, 0);

        // Over-current only while blanked is ignored.
        for (int i = 0; i < 10; i++) period(1'b1, 11'd1990, 1'b1, 1'b0, 1'b0);
        chk_out("blanked", 1990, 0, 0);
        for (int i = 0; i < 3; i++) period(1'b1, 11'd1990, 1'b1, 1'b1, 1'b0);
        chk_out("after_blank_burst3", 1990, 0, 0);
        period(1'b1, 11'd1990, 1'b0, 1'b1, 1'b0);

        // Trip at duty=500; fourth period's sample only on the synch cycle.
        do_reset();
        for (int i = 0; i < 32; i++) period(1'b1, 11'd500, 1'b0, 1'b1, 1'b0);
        chk_out("at500", 500, 0, 0);
        for (int i = 0; i < 3; i++) begin
            period(1'b1, 11'd500, 1'b1, 1'b1, 1'b0);
            chk_out($sformatf("pretrip%0d", i + 1), 500, 0, 0);
        end
        period(1'b1, 11'd500, 1'b1, 1'b1, 1'b1);
        chk_out("trip", 0, 0, 1);
        $display("trip duty=%0d shutdown=%0d", duty, shutdown);
        for (int i = 0; i < 2; i++) period(1'b1, 11'd500, 1'b0, 1'b1, 1'b0);
        chk_out("fault_hold_en1", 0, 0, 1);
        en = 1'b0;
        repeat (3) @(negedge clk);
        chk_out("fault_no_synch", 0, 0, 1);
        period(1'b0, 11'd500, 1'b0, 1'b1, 1'b0);
        chk_out("fault_exit", 0, 0, 0);
        period(1'b1, 11'd500, 1'b0, 1'b1, 1'b0);
        chk_out("restart", 16, 1, 0);

        // 3-burst, clean period, 3-burst: count clears, never trips.
        for (int i = 0; i < 3; i++) period(1'b1, 11'd500, 1'b1, 1'b1, 1'b0);
        chk_out("burstA", 64, 1, 0);
        period(1'b1, 11'd500, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) period(1'b1, 11'd500, 1'b1, 1'b1, 1'b0);
        chk_out("burstB", 128, 1, 0);

        // Mid-ramp reset.
        do_reset();
        for (int i = 0; i < 4; i++) period(1'b1, 11'd100, 1'b0, 1'b1, 1'b0);
        chk_out("pre_reset64", 64, 1, 0);
        rst_n = 1'b0;
        @(negedge clk);
        chk_out("mid_reset", 0, 0, 0);
        rst_n = 1'b1;
        period(1'b1, 11'd100, 1'b0, 1'b1, 1'b0);
        chk_out("post_reset", 16, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
